// File: rtl/uart_rx_os.sv
// UART receiver (8 data bits, optional parity). It synchronises the rx line, votes 2-of-3
// around mid-bit, rejects false starts, and hands bytes out on a valid/ready handshake.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned Mid        = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  localparam logic [CntW-1:0] CntMax   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntEarly = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntMid   = CntW'(Mid);
  localparam logic [CntW-1:0] CntLate  = CntW'(Mid + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [1:0]      warm_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            s_early_q, s_early_d;
  logic            s_mid_q, s_mid_d;
  logic            perr_q, perr_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_out_q, perr_out_d;
  logic            overrun_q, overrun_d;

  logic fall_edge;
  logic decide;
  logic vote;
  logic exp_par;
  logic stop_dec;
  logic load;

  // Synchroniser flops reset high, so the first two post-reset samples are not real line
  // values; arming waits until the synced line has genuinely been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign armed_d   = armed_q | (warm_q[1] & sync2_q);
  assign fall_edge = armed_q & prev_q & ~sync2_q;
  assign decide    = (cnt_q == CntLate);
  assign vote      = (s_early_q & s_mid_q) | (s_early_q & sync2_q) | (s_mid_q & sync2_q);
  assign exp_par   = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      s_early_q  <= 1'b1;
      s_mid_q    <= 1'b1;
      perr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      s_early_q  <= s_early_d;
      s_mid_q    <= s_mid_d;
      perr_q     <= perr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    s_early_d = (cnt_q == CntEarly) ? sync2_q : s_early_q;
    s_mid_d   = (cnt_q == CntMid) ? sync2_q : s_mid_q;
    perr_d    = perr_q;
    stop_dec  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall_edge) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (decide) begin
          if (vote) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
            perr_d    = 1'b0;
          end
        end
      end
      StData: begin
        if (decide) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (decide) begin
          perr_d  = vote ^ exp_par;
          state_d = StStop;
        end
      end
      StStop: begin
        // Return to idle on the decision edge so a start in the late stop half is caught.
        if (decide) begin
          stop_dec = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load = stop_dec & (~rx_valid_q | rx_ready_i);

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    overrun_d  = 1'b0;
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      ferr_d     = ~vote;
      perr_out_d = perr_q;
    end else if (stop_dec) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_out_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 16 clocks per bit, scoreboard of expected bytes.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx_p;
  logic       rdy, rdy_p;
  logic [7:0] rx_data, d_e, d_odd;
  logic       rx_valid, v_e, v_odd;
  logic       ferr, fe_e, fe_odd;
  logic       perr, pe_e, pe_odd;
  logic       ovr, ov_e, ov_odd;
  logic       busy, b_e, b_odd;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ovr) ovr_cnt <= ovr_cnt + 1;

  uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx0), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rdy), .frame_err_o(ferr), .parity_err_o(perr), .overrun_o(ovr),
    .busy_o(busy)
  );

  uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(2)) dut_even (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .rx_data_o(d_e), .rx_valid_o(v_e),
    .rx_ready_i(rdy_p), .frame_err_o(fe_e), .parity_err_o(pe_e), .overrun_o(ov_e),
    .busy_o(b_e)
  );

  uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .rx_data_o(d_odd), .rx_valid_o(v_odd),
    .rx_ready_i(rdy_p), .frame_err_o(fe_odd), .parity_err_o(pe_odd), .overrun_o(ov_odd),
    .busy_o(b_odd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit on_p);
    if (on_p) rx_p = b;
    else rx0 = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit with_par,
                            input logic par_b, input bit on_p);
    send_bit(1'b0, on_p);
    for (int i = 0; i < 8; i++) send_bit(d[i], on_p);
    if (with_par) send_bit(par_b, on_p);
    send_bit(stop_b, on_p);
  endtask

  task automatic wait_valid(input bit on_p, input string tag);
    int n = 0;
    while (((on_p ? v_e : rx_valid) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, on_p ? v_e : rx_valid, 1);
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    wait_valid(1'b0, {tag, "_valid"});
    chk({tag, "_sb_pending"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, rx_data, e.d);
      chk({tag, "_ferr"}, ferr, e.fe);
      chk({tag, "_perr"}, perr, e.pe);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk({tag, "_accept_clears"}, rx_valid, 0);
  endtask

  task automatic parity_case(input logic [7:0] d, input logic par_b, input string tag);
    send_frame(d, 1'b1, 1'b1, par_b, 1'b1);
    wait_valid(1'b1, {tag, "_even_valid"});
    chk({tag, "_odd_valid"}, v_odd, 1);
    chk({tag, "_even_data"}, d_e, d);
    chk({tag, "_even_ferr"}, fe_e, 0);
    chk({tag, "_even_perr"}, pe_e, par_b != (^d));
    chk({tag, "_odd_perr"}, pe_odd, par_b != ~(^d));
    rdy_p = 1'b1;
    @(negedge clk);
    rdy_p = 1'b0;
    chk({tag, "_even_clears"}, v_e, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ovr0;
    rst_n = 1'b0;
    rx0   = 1'b0;  // line low through reset release
    rx_p  = 1'b1;
    rdy   = 1'b0;
    rdy_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("low_release_busy", busy, 0);
    chk("low_release_valid", rx_valid, 0);
    rx0 = 1'b1;
    repeat (32) @(negedge clk);
    chk("low_release_idle", busy, 0);

    // Basic frame, held without acceptance.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    repeat (100) @(negedge clk);
    chk("t1_held_valid", rx_valid, 1);
    chk("t1_held_data", rx_data, 8'hA5);
    expect_frame("t1");

    // False start: 3-cycle low pulse.
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_false_busy", busy, 1);
    repeat (10) @(negedge clk);
    chk("t2_false_idle", busy, 0);
    chk("t2_false_novalid", rx_valid, 0);
    repeat (20) @(negedge clk);

    // 0xFF with a one-cycle glitch at the middle of data bit 2.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rx0 = 1'b1;
    repeat (9) @(negedge clk);
    rx0 = 1'b0;
    @(negedge clk);
    rx0 = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    sb.push_back('{d: 8'hFF, fe: 1'b0, pe: 1'b0});
    expect_frame("t2_glitch");

    // Framing error followed by a break.
    repeat (16) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    expect_frame("t3_ferr");
    repeat (80) @(negedge clk);
    chk("t3_break_busy", busy, 0);
    chk("t3_break_valid", rx_valid, 0);
    rx0 = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    expect_frame("t3_after_break");

    // Overrun: second byte dropped while first is unaccepted.
    repeat (16) @(negedge clk);
    ovr0 = ovr_cnt;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h01, fe: 1'b0, pe: 1'b0});
    send_frame(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_overrun_once", ovr_cnt - ovr0, 1);
    chk("t4_kept_data", rx_data, 8'h01);
    expect_frame("t4_first");
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b0});
    expect_frame("t4_third");

    // Accept on the same edge as the next completion: new byte loads, no overrun.
    send_frame(8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_pending_data", rx_data, 8'h06);
    ovr0 = ovr_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'h04 >> i) & 8'h01) != 0, 1'b0);
    rx0 = 1'b1;
    repeat (12) @(negedge clk);
    chk("t4_same_edge_pre_valid", rx_valid, 1);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("t4_same_edge_valid", rx_valid, 1);
    chk("t4_same_edge_data", rx_data, 8'h04);
    repeat (4) @(negedge clk);
    chk("t4_same_edge_no_ovr", ovr_cnt - ovr0, 0);

    // Parity: even and odd receivers share one line.
    parity_case(8'h07, 1'b0, "t5_par0");
    repeat (16) @(negedge clk);
    parity_case(8'h07, 1'b1, "t5_par1");

    // Asynchronous reset during data bit 3 while a byte is still held.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rx0 = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_ferr", ferr, 0);
    chk("t6_rst_perr", perr, 0);
    chk("t6_rst_ovr", ovr, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_release_busy", busy, 0);
    chk("t6_release_valid", rx_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    expect_frame("t6_after_reset");
    repeat (200) @(negedge clk);
    chk("t6_no_spurious", rx_valid, 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
